// File: rtl/rgbled_rx.sv
// WS2812-style one-wire LED stream decoder: classifies high pulses by width,
// assembles MSB-first 24-bit pixels and flags frame latches and malformed pulses.
module rgbled_rx #(
  parameter int SysClkFreq     = 40_000_000,
  parameter bit InvertIn       = 1'b0,
  parameter int MinHighNs      = 150,
  parameter int BitThresholdNs = 600,
  parameter int MaxHighNs      = 2000,
  parameter int ResetNs        = 50_000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        din_i,
  output logic [23:0] pixel_o,
  output logic        pixel_valid_o,
  input  logic        pixel_ready_i,
  output logic        latch_o,
  output logic        pulse_err_o,
  output logic        overflow_o,
  input  logic        clear_i,
  output logic [15:0] pixel_count_o
);

  localparam longint NsPerSec      = 64'd1_000_000_000;
  localparam int     MinHighCycles = int'(longint'(MinHighNs) * longint'(SysClkFreq) / NsPerSec);
  localparam int     ThreshCycles  = int'(longint'(BitThresholdNs) * longint'(SysClkFreq) / NsPerSec);
  localparam int     MaxHighCycles = int'(longint'(MaxHighNs) * longint'(SysClkFreq) / NsPerSec);
  localparam int     ResetCycles   = int'(longint'(ResetNs) * longint'(SysClkFreq) / NsPerSec);

  localparam int HW = $clog2(MaxHighCycles + 1);
  localparam int LW = $clog2(ResetCycles + 1);

  localparam logic [HW:0]   MinH     = (HW+1)'(MinHighCycles);
  localparam logic [HW:0]   ThreshH  = (HW+1)'(ThreshCycles);
  localparam logic [HW:0]   MaxH     = (HW+1)'(MaxHighCycles);
  localparam logic [LW-1:0] ResetL   = LW'(ResetCycles);
  localparam logic [LW-1:0] ResetLm1 = LW'(ResetCycles - 1);

  typedef enum logic [1:0] {WAIT_LOW, LOW, HIGH} state_e;

  // Synchroniser and edge detect. Reset preloads the "line high" value so a
  // pulse already in progress at reset release is held off by WAIT_LOW.
  logic [1:0] sync_q;
  logic       line, line_q, rise, fall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{~InvertIn}};
      line_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], din_i};
      line_q <= line;
    end
  end

  assign line = sync_q[1] ^ InvertIn;
  assign rise = line & ~line_q;
  assign fall = ~line & line_q;

  state_e        state_q, state_d;
  logic [LW-1:0] low_q, low_d;
  logic [HW-1:0] hi_q, hi_d;
  logic [22:0]   shift_q, shift_d;
  logic [4:0]    bits_q, bits_d;
  logic [23:0]   pix_d;
  logic          vld_d, ovf_d, latch_d, err_d;
  logic [15:0]   cnt_d;
  logic [HW:0]   h;
  logic          bit_val, done, ovf_set;

  // h is the number of cycles the line has been high before this cycle.
  assign h = {1'b0, hi_q} + (HW+1)'(1);

  always_comb begin
    state_d = state_q;
    low_d   = low_q;
    hi_d    = hi_q;
    shift_d = shift_q;
    bits_d  = bits_q;
    pix_d   = pixel_o;
    vld_d   = pixel_valid_o;
    ovf_d   = overflow_o;
    cnt_d   = pixel_count_o;
    latch_d = 1'b0;
    err_d   = 1'b0;
    bit_val = 1'b0;
    done    = 1'b0;
    ovf_set = 1'b0;

    unique case (state_q)
      WAIT_LOW: begin
        if (!line) begin
          state_d = LOW;
          low_d   = '0;
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
          hi_d    = '0;
        end else if (low_q != ResetL) begin
          low_d = low_q + LW'(1);
          if (low_q == ResetLm1) begin
            latch_d = (bits_q != 5'd0) || (pixel_count_o != 16'd0);
            err_d   = (bits_q != 5'd0);
            bits_d  = 5'd0;
            cnt_d   = 16'd0;
          end
        end
      end
      HIGH: begin
        if (fall) begin
          state_d = LOW;
          if (h < MinH) begin
            err_d = 1'b1;
          end else if (h >= MaxH) begin
            err_d  = 1'b1;
            bits_d = 5'd0;
            low_d  = '0;
          end else begin
            bit_val = (h >= ThreshH);
            shift_d = {shift_q[21:0], bit_val};
            low_d   = '0;
            if (bits_q == 5'd23) begin
              bits_d = 5'd0;
              done   = 1'b1;
            end else begin
              bits_d = bits_q + 5'd1;
            end
          end
        end else if (h >= MaxH) begin
          // Stuck high: drop the partial pixel and resync on the next low.
          err_d   = 1'b1;
          bits_d  = 5'd0;
          state_d = WAIT_LOW;
        end else begin
          hi_d = hi_q + HW'(1);
        end
      end
      default: state_d = WAIT_LOW;
    endcase

    if (done) begin
      if (pixel_count_o != 16'hFFFF) cnt_d = pixel_count_o + 16'd1;
      if (!pixel_valid_o || pixel_ready_i) begin
        pix_d = {shift_q, bit_val};
        vld_d = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (pixel_valid_o && pixel_ready_i) begin
      vld_d = 1'b0;
    end

    if (ovf_set)      ovf_d = 1'b1;
    else if (clear_i) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= WAIT_LOW;
      low_q         <= '0;
      hi_q          <= '0;
      shift_q       <= '0;
      bits_q        <= '0;
      pixel_o       <= '0;
      pixel_valid_o <= 1'b0;
      overflow_o    <= 1'b0;
      pixel_count_o <= '0;
      latch_o       <= 1'b0;
      pulse_err_o   <= 1'b0;
    end else begin
      state_q       <= state_d;
      low_q         <= low_d;
      hi_q          <= hi_d;
      shift_q       <= shift_d;
      bits_q        <= bits_d;
      pixel_o       <= pix_d;
      pixel_valid_o <= vld_d;
      overflow_o    <= ovf_d;
      pixel_count_o <= cnt_d;
      latch_o       <= latch_d;
      pulse_err_o   <= err_d;
    end
  end

endmodule

// File: tb/tb_rgbled_rx.sv
// Bench for rgbled_rx: a normal and an inverted-input instance see the same
// logical stream; delivered pixels are checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_rgbled_rx;
  logic clk = 1'b0, rst_n = 1'b0, din = 1'b0, ready = 1'b0, clr = 1'b0;
  logic din_n;
  logic [23:0] pix, pix_i;
  logic [15:0] cnt, cnt_i;
  logic vld, vld_i, lat, lat_i, err, err_i, ovf, ovf_i;

  int n_chk = 0, n_err = 0;
  int n_lat = 0, n_lat_i = 0, n_perr = 0, n_perr_i = 0, n_both = 0, n_both_i = 0;
  int l0, l0i, e0, e0i, b0, b0i;
  logic [23:0] exp_q[$], exp_qi[$];

  assign din_n = ~din;
  always #12.5 clk = ~clk;

  rgbled_rx dut (
    .clk_i(clk), .rst_ni(rst_n), .din_i(din), .pixel_o(pix), .pixel_valid_o(vld),
    .pixel_ready_i(ready), .latch_o(lat), .pulse_err_o(err), .overflow_o(ovf),
    .clear_i(clr), .pixel_count_o(cnt));

  rgbled_rx #(.InvertIn(1'b1)) dut_inv (
    .clk_i(clk), .rst_ni(rst_n), .din_i(din_n), .pixel_o(pix_i), .pixel_valid_o(vld_i),
    .pixel_ready_i(ready), .latch_o(lat_i), .pulse_err_o(err_i), .overflow_o(ovf_i),
    .clear_i(clr), .pixel_count_o(cnt_i));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [31:0] a, input logic [31:0] ai,
                      input logic [31:0] e);
    chk(tag, a, e);
    chk({tag, "_inv"}, ai, e);
  endtask

  // Monitor on the falling edge: inputs change just after the rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (lat)   n_lat++;
      if (lat_i) n_lat_i++;
      if (err)   n_perr++;
      if (err_i) n_perr_i++;
      if (lat && err)     n_both++;
      if (lat_i && err_i) n_both_i++;
      if (vld && ready) begin
        chk("pop_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("pixel_hs", pix, exp_q.pop_front());
      end
      if (vld_i && ready) begin
        chk("pop_nonempty_inv", 32'(exp_qi.size() != 0), 1);
        if (exp_qi.size() != 0) chk("pixel_hs_inv", pix_i, exp_qi.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hi_lo(input int h, input int l);
    din = 1'b1; cyc(h);
    din = 1'b0; cyc(l);
  endtask

  task automatic send_bit(input logic b);
    if (b) hi_lo(32, 18);
    else   hi_lo(16, 34);
  endtask

  task automatic send_px(input logic [23:0] p, input logic push);
    if (push) begin
      exp_q.push_back(p);
      exp_qi.push_back(p);
    end
    for (int i = 23; i >= 0; i--) send_bit(p[i]);
  endtask

  task automatic snap();
    l0 = n_lat; l0i = n_lat_i; e0 = n_perr; e0i = n_perr_i; b0 = n_both; b0i = n_both_i;
  endtask

  initial begin
    logic [21:0] tail;
    logic [9:0]  ten;
    rst_n = 1'b0;
    cyc(3);
    chk2("rst_pixel", pix, pix_i, 0);
    chk2("rst_valid", vld, vld_i, 0);
    chk2("rst_count", cnt, cnt_i, 0);
    chk2("rst_ovf", ovf, ovf_i, 0);
    chk2("rst_latch", lat, lat_i, 0);
    chk2("rst_err", err, err_i, 0);
    rst_n = 1'b1;
    cyc(10);

    // Single pixel held (no consumer), then frame latch.
    ready = 1'b0; snap();
    send_px(24'hA5C33C, 1'b1);
    chk2("s1_count", cnt, cnt_i, 1);
    chk2("s1_valid", vld, vld_i, 1);
    chk2("s1_pixel", pix, pix_i, 24'hA5C33C);
    cyc(2100);
    chk2("s1_latch", n_lat - l0, n_lat_i - l0i, 1);
    chk2("s1_noerr", n_perr - e0, n_perr_i - e0i, 0);
    chk2("s1_count0", cnt, cnt_i, 0);
    ready = 1'b1; cyc(3);
    chk2("s1_drain", exp_q.size(), exp_qi.size(), 0);
    chk2("s1_valid0", vld, vld_i, 0);

    // Three pixels streamed with a ready consumer.
    snap();
    send_px(24'h000000, 1'b1); chk2("s2_count1", cnt, cnt_i, 1);
    send_px(24'hFFFFFF, 1'b1); chk2("s2_count2", cnt, cnt_i, 2);
    send_px(24'h123456, 1'b1); chk2("s2_count3", cnt, cnt_i, 3);
    cyc(2100);
    chk2("s2_latch", n_lat - l0, n_lat_i - l0i, 1);
    chk2("s2_noerr", n_perr - e0, n_perr_i - e0i, 0);
    chk2("s2_count0", cnt, cnt_i, 0);
    chk2("s2_drain", exp_q.size(), exp_qi.size(), 0);

    // No consumer: first pixel held, later ones dropped as overflow.
    ready = 1'b0;
    send_px(24'h000000, 1'b1); chk2("s3_ovf0", ovf, ovf_i, 0);
    send_px(24'hFFFFFF, 1'b0); chk2("s3_ovf1", ovf, ovf_i, 1);
    send_px(24'h123456, 1'b0);
    chk2("s3_pixel", pix, pix_i, 24'h000000);
    chk2("s3_valid", vld, vld_i, 1);
    chk2("s3_count", cnt, cnt_i, 3);
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk2("s3_clear", ovf, ovf_i, 0);
    cyc(2100);
    ready = 1'b1; cyc(3);
    chk2("s3_drain", exp_q.size(), exp_qi.size(), 0);

    // Width boundaries: 23 -> 0, 24 -> 1, a 4-cycle glitch records nothing.
    snap();
    tail = 22'h2AAAAA;
    exp_q.push_back({2'b01, tail});
    exp_qi.push_back({2'b01, tail});
    hi_lo(23, 30);
    hi_lo(24, 30);
    hi_lo(4, 30);
    chk2("s4_glitch_err", n_perr - e0, n_perr_i - e0i, 1);
    for (int i = 21; i >= 0; i--) send_bit(tail[i]);
    cyc(5);
    chk2("s4_bound_px", exp_q.size(), exp_qi.size(), 0);
    // Overlong pulse drops 10 partial bits, then the line resyncs.
    snap();
    ten = 10'h2CB;
    for (int i = 9; i >= 0; i--) send_bit(ten[i]);
    hi_lo(90, 40);
    chk2("s4_long_err", n_perr - e0, n_perr_i - e0i, 1);
    send_px(24'hC0FFEE, 1'b1);
    cyc(5);
    chk2("s4_resync_px", exp_q.size(), exp_qi.size(), 0);
    cyc(2100);
    chk2("s4_latch", n_lat - l0, n_lat_i - l0i, 1);
    chk2("s4_err_total", n_perr - e0, n_perr_i - e0i, 1);

    // Partial pixel cut by a latch: latch and error together, bits dropped.
    snap();
    for (int i = 9; i >= 0; i--) send_bit(ten[i]);
    cyc(2100);
    chk2("s5_latch", n_lat - l0, n_lat_i - l0i, 1);
    chk2("s5_err", n_perr - e0, n_perr_i - e0i, 1);
    chk2("s5_both", n_both - b0, n_both_i - b0i, 1);
    chk2("s5_valid0", vld, vld_i, 0);
    send_px(24'h5A5A5A, 1'b1);
    cyc(5);
    chk2("s5_next_px", exp_q.size(), exp_qi.size(), 0);
    cyc(2100);

    // Reset mid-pixel with the line high across reset release.
    ready = 1'b0;
    for (int i = 0; i < 12; i++) send_bit(i[0]);
    din = 1'b1; cyc(10);
    rst_n = 1'b0; cyc(2);
    chk2("s6_rst_pixel", pix, pix_i, 0);
    chk2("s6_rst_valid", vld, vld_i, 0);
    chk2("s6_rst_count", cnt, cnt_i, 0);
    chk2("s6_rst_ovf", ovf, ovf_i, 0);
    rst_n = 1'b1; cyc(20);
    din = 1'b0; cyc(40);
    snap(); ready = 1'b1;
    send_px(24'h0F0F0F, 1'b1);
    cyc(5);
    chk2("s6_px", exp_q.size(), exp_qi.size(), 0);
    chk2("s6_count", cnt, cnt_i, 1);
    chk2("s6_noerr", n_perr - e0, n_perr_i - e0i, 0);
    cyc(2100);
    chk2("s6_latch", n_lat - l0, n_lat_i - l0i, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
